serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port SHALL be: clk  input  1  single system clock, rising-edge active.
REQ-003 Port SHALL be: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port SHALL be: start  input  1  request an addition; sampled only in IDLE.
REQ-005 Port SHALL be: a  input  WIDTH  operand A; captured on the accepted start edge.
REQ-006 Port SHALL be: b  input  WIDTH  operand B; captured on the accepted start edge.
REQ-007 Port SHALL be: cin  input  1  carry-in; captured on the accepted start edge.
REQ-008 Port SHALL be: busy  output  1  high while an operation is in progress.
REQ-009 Port SHALL be: done  output  1  one-cycle pulse when the result is valid.
REQ-010 Port SHALL be: sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-011 Port SHALL be: cout  output  1  carry-out of the MSB; held with sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin using a single 1-bit full-adder slice (sum = x^y^c, carry = majority) time-shared over WIDTH cycles, LSB first.
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture a, b and cin into shift and carry registers, clear the bit counter, and enter RUN.
REQ-015 In RUN, each edge SHALL process one bit, shift the result bit into sum from the MSB side, update the carry register, and increment the counter.
REQ-016 After the WIDTH-th RUN edge, the FSM SHALL enter DONE with the final sum and cout registered.
REQ-017 In DONE, done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-018 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never both be 1.
REQ-019 Latency SHALL be: start accepted at edge T; done high in the cycle following edge T+WIDTH; the next start is accepted no earlier than edge T+WIDTH+2.
REQ-020 start asserted in RUN or DONE SHALL be ignored, with no queuing; start held high continuously SHALL cause back-to-back operations, one per WIDTH+2 cycles.
REQ-021 Changes on a, b or cin after capture SHALL NOT affect the operation in progress.
REQ-022 Carry SHALL wrap naturally: all-ones + all-ones + 1 SHALL yield sum all-ones with cout=1; no other overflow flag.
REQ-023 sum and cout SHALL be visibly partial while busy=1; they are valid only from done onward.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE and clear busy=0, done=0, sum=0, cout=0, the counter and the carry register, regardless of clock.
REQ-025 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL operate normally.
REQ-026 Release of rst_n is synchronous to clk, handled externally; start on the first edge after release SHALL be accepted.

Configuration
REQ-027 Macro SERIAL_ADDER_SUB_EN, when defined, SHALL add port: sub  input  1  captured on the accepted start edge; sub=1 SHALL compute a + ~b + 1 (cin ignored), with cout=1 meaning no borrow; sub=0 behaves per REQ-012.
REQ-028 When SERIAL_ADDER_SUB_EN is undefined, port sub SHALL be absent and the block SHALL perform addition only, with identical timing.

Verification (WIDTH=8)
REQ-029 Reset, then a=0x35, b=0x4A, cin=0, start for 1 cycle -> busy for 8 cycles, done for 1 cycle, sum=0x7F, cout=0.
REQ-030 a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
REQ-031 Pulse start again at cycle 3 of RUN and change a/b mid-RUN -> result unchanged from captured operands, exactly one done pulse.
REQ-032 Hold start high for 30 cycles with a=0x10, b=0x20 -> done pulses spaced 10 cycles apart, each with sum=0x30.
REQ-033 Assert rst_n low at RUN cycle 4 -> outputs zero immediately, no done pulse; next op a=0x01, b=0x02 -> sum=0x03.
REQ-034 With SERIAL_ADDER_SUB_EN: sub=1, a=0x10, b=0x03 -> sum=0x0D, cout=1; a=0x03, b=0x10 -> sum=0xF3, cout=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder. One full-adder slice is reused over
// WIDTH clock cycles, LSB first, to form {cout,sum} = a + b + cin.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds input 'sub'. With sub=1 the
// block computes a + ~b + 1 (cin ignored); cout=1 then means "no borrow".
//
// Handshake: start is sampled only in IDLE. busy is high for the WIDTH RUN
// cycles. done is a one-cycle pulse, never high together with busy. sum and
// cout are valid from done until the next accepted start; they are partial
// while busy is high.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_b_in;
   logic             w_c_in;
   logic             w_bit;
   logic             w_carry;

   // Operand B and carry-in as loaded at start; subtraction inverts B and forces carry-in.
`ifdef SERIAL_ADDER_SUB_EN
   assign w_b_in = sub ? ~b : b;
   assign w_c_in = sub ? 1'b1 : cin;
`else
   assign w_b_in = b;
   assign w_c_in = cin;
`endif

   // The single shared full-adder slice works on the LSBs of the shift registers.
   assign w_bit   = r_a[0] ^ r_b[0] ^ r_carry;
   assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

   // Controller FSM and datapath registers, all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= a;
                  r_b     <= w_b_in;
                  r_carry <= w_c_in;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               // Result bits enter from the MSB side so bit 0 lands at sum[0] after WIDTH shifts.
               r_sum   <= {w_bit, r_sum[WIDTH-1:1]};
               r_carry <= w_carry;
               r_cout  <= w_carry;
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST_BIT) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // start is ignored here; the earliest new start is the edge after this one.
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vectors with hand-computed results for the
// bit-serial adder at WIDTH=8. Define SERIAL_ADDER_SUB_EN to include the
// subtraction vectors.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // ---------------- scoreboard ----------------
   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] obs_q[$];
   int             done_cyc_q[$];
   int             busy_cnt;
   int             overlap_cnt;
   int             n_chk = 0;
   int             n_err = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Each iteration samples outputs on the falling edge, then crosses one
   // rising edge and returns 1 time unit after it (where inputs are driven).
   task automatic watch(input int n);
      repeat (n) begin
         @(negedge clk);
         if (done) begin
            obs_q.push_back({cout, sum});
            done_cyc_q.push_back(cyc);
         end
         if (busy) busy_cnt++;
         if (busy && done) overlap_cnt++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_obs();
      obs_q.delete();
      done_cyc_q.delete();
      busy_cnt    = 0;
      overlap_cnt = 0;
   endtask

   // Launch one operation, scramble the inputs right after capture, and check
   // busy length, single done pulse, latency, value and hold of the result.
   task automatic do_op(input string tag, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic cv,
                        input logic [WIDTH:0] expv);
      int t0;
      clear_obs();
      exp_q.push_back(expv);
      a = av; b = bv; cin = cv; start = 1'b1;
      watch(1);
      start = 1'b0;
      t0 = cyc;
      a = ~av; b = ~bv; cin = ~cv;
      watch(12);
      check({tag, "_busy_cycles"}, busy_cnt, 8);
      check({tag, "_done_pulses"}, obs_q.size(), 1);
      check({tag, "_overlap"}, overlap_cnt, 0);
      if (obs_q.size() > 0) begin
         check({tag, "_latency"}, done_cyc_q[0] - t0, 8);
         check({tag, "_result"}, obs_q[0], exp_q.pop_front());
      end else begin
         void'(exp_q.pop_front());
      end
      check({tag, "_held"}, {cout, sum}, expv);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int t_first;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      #3;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // basic additions
      do_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 9'h07F);
      do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
      do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
      do_op("add_80_80_c", 8'h80, 8'h80, 1'b1, 9'h101);
      do_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 9'h010);
      do_op("add_5a_a5_c", 8'h5A, 8'hA5, 1'b1, 9'h100);

      // start pulsed and operands changed during RUN cycle 3
      clear_obs();
      a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
      watch(1);
      start = 1'b0;
      watch(2);
      start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
      watch(1);
      start = 1'b0; a = 8'h00; b = 8'h00;
      watch(12);
      check("midrun_done_pulses", obs_q.size(), 1);
      if (obs_q.size() > 0) check("midrun_result", obs_q[0], 9'h047);

      // start held high: back-to-back operations every WIDTH+2 cycles
      clear_obs();
      for (int i = 0; i < 3; i++) exp_q.push_back(9'h030);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      watch(30);
      start = 1'b0;
      watch(12);
      check("b2b_done_pulses", obs_q.size(), 3);
      check("b2b_overlap", overlap_cnt, 0);
      for (int i = 0; i < obs_q.size() && i < 3; i++) begin
         check($sformatf("b2b_result%0d", i), obs_q[i], exp_q.pop_front());
         if (i > 0) check($sformatf("b2b_spacing%0d", i), done_cyc_q[i] - done_cyc_q[i-1], 10);
      end
      exp_q.delete();

      // reset during RUN cycle 4
      clear_obs();
      a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
      watch(1);
      start = 1'b0;
      t_first = cyc;
      watch(3);
      check("pre_rst_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      watch(3);
      rst_n = 1'b1;
      watch(8);
      check("midrst_no_done", obs_q.size(), 0);
      check("midrst_elapsed", cyc - t_first >= 11, 1);
      do_op("after_rst", 8'h01, 8'h02, 1'b0, 9'h003);

`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b1;
      do_op("sub_10_03", 8'h10, 8'h03, 1'b0, 9'h10D);
      do_op("sub_03_10", 8'h03, 8'h10, 1'b1, 9'h0F3);
      sub = 1'b0;
      do_op("sub_off_add", 8'h10, 8'h03, 1'b1, 9'h014);
`endif

      // final report
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no end of stimulus, required completion");
      $fatal(1);
   end

endmodule
